// File: rtl/control_registro_desplazable.sv
// control_registro_desplazable
// Sequencer for a WIDTH-bit shift register. Takes one command at a time over
// a valid/ready handshake and drives the register to load, serialize, rotate
// or deserialize a word. Completion is flagged with a one-cycle DONE pulse.
// Ports:
//   clk, RST_N                      clock, async active-low reset
//   CMD_VALID/CMD_READY             command handshake (READY only in IDLE)
//   CMD_OP/DIR/DATA/AMT/FILL        command fields, latched on accept
//   SIN_EXT                         serial input for deserialize
//   SER_BIT/SER_VALID               bit leaving the register while serializing
//   RESULT, DONE, ERR               final register word, completion, illegal op
//   REG_ENB/DIR/SIN/MODO/D          registered controls to the shift register
//   REG_Q, REG_SOUT                 register contents and serial output
module control_registro_desplazable #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 2
) (
  input  logic             clk,
  input  logic             RST_N,
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic [1:0]       CMD_OP,
  input  logic             CMD_DIR,
  input  logic [WIDTH-1:0] CMD_DATA,
  input  logic [CNT_W-1:0] CMD_AMT,
  input  logic             CMD_FILL,
  input  logic             SIN_EXT,
  output logic             SER_BIT,
  output logic             SER_VALID,
  output logic [WIDTH-1:0] RESULT,
  output logic             DONE,
  output logic             ERR,
  output logic             REG_ENB,
  output logic             REG_DIR,
  output logic             REG_SIN,
  output logic [1:0]       REG_MODO,
  output logic [WIDTH-1:0] REG_D,
  input  logic [WIDTH-1:0] REG_Q,
  input  logic             REG_SOUT
);

  localparam logic [1:0] OP_SER = 2'b00;
  localparam logic [1:0] OP_ROT = 2'b01;
  localparam logic [1:0] OP_DES = 2'b10;

  localparam logic [1:0] MODO_SHIFT = 2'b00;
  localparam logic [1:0] MODO_ROT   = 2'b01;
  localparam logic [1:0] MODO_LOAD  = 2'b10;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_ROT,
    S_DONE
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       op_q;
  logic             fill_q;
  logic [CNT_W-1:0] amt_q;
  logic [WIDTH-1:0] result_q;
  logic             err_q;
  logic             reg_enb_q;
  logic             reg_dir_q;
  logic             reg_sin_q;
  logic [1:0]       reg_modo_q;
  logic [WIDTH-1:0] reg_d_q;
  logic             accept;

  assign CMD_READY = (state_q == S_IDLE);
  assign accept    = CMD_VALID & CMD_READY;
  assign SER_VALID = (state_q == S_SHIFT) && (op_q == OP_SER);
  assign SER_BIT   = REG_SOUT;
  assign DONE      = (state_q == S_DONE);
  // The register settles on the edge entering DONE, so show it live during
  // DONE and hold the captured copy afterwards.
  assign RESULT    = (state_q == S_DONE) ? REG_Q : result_q;
  assign ERR       = err_q;
  assign REG_ENB   = reg_enb_q;
  assign REG_DIR   = reg_dir_q;
  assign REG_SIN   = reg_sin_q;
  assign REG_MODO  = reg_modo_q;
  assign REG_D     = reg_d_q;

  // Sequencer: register controls are set up one edge ahead of the state they serve.
  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      op_q       <= OP_SER;
      fill_q     <= 1'b0;
      amt_q      <= '0;
      result_q   <= '0;
      err_q      <= 1'b0;
      reg_enb_q  <= 1'b0;
      reg_dir_q  <= 1'b0;
      reg_sin_q  <= 1'b0;
      reg_modo_q <= MODO_SHIFT;
      reg_d_q    <= '0;
    end else begin
      err_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            op_q   <= CMD_OP;
            fill_q <= CMD_FILL;
            amt_q  <= CMD_AMT;
            unique case (CMD_OP)
              OP_SER, OP_ROT: begin
                state_q    <= S_LOAD;
                reg_enb_q  <= 1'b1;
                reg_modo_q <= MODO_LOAD;
                reg_d_q    <= CMD_DATA;
                reg_dir_q  <= CMD_DIR;
              end
              OP_DES: begin
                state_q    <= S_SHIFT;
                cnt_q      <= CNT_LAST;
                reg_enb_q  <= 1'b1;
                reg_modo_q <= MODO_SHIFT;
                reg_dir_q  <= CMD_DIR;
                reg_sin_q  <= SIN_EXT;
              end
              default: begin
                err_q <= 1'b1;
              end
            endcase
          end
        end
        S_LOAD: begin
          if (op_q == OP_SER) begin
            state_q    <= S_SHIFT;
            cnt_q      <= CNT_LAST;
            reg_modo_q <= MODO_SHIFT;
            reg_sin_q  <= fill_q;
          end else if (amt_q != '0) begin
            state_q    <= S_ROT;
            cnt_q      <= amt_q - CNT_W'(1);
            reg_modo_q <= MODO_ROT;
          end else begin
            state_q   <= S_DONE;
            reg_enb_q <= 1'b0;
          end
        end
        S_SHIFT: begin
          if (cnt_q == '0) begin
            state_q   <= S_DONE;
            reg_enb_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
            if (op_q == OP_DES) begin
              reg_sin_q <= SIN_EXT;
            end
          end
        end
        S_ROT: begin
          if (cnt_q == '0) begin
            state_q   <= S_DONE;
            reg_enb_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_DONE: begin
          state_q  <= S_IDLE;
          result_q <= REG_Q;
        end
        default: begin
          state_q   <= S_IDLE;
          reg_enb_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_control_registro_desplazable.sv
// Bench for control_registro_desplazable: models the attached shift register
// and checks each command against results derived from plain arithmetic.
module tb_control_registro_desplazable;

  localparam int unsigned W  = 4;
  localparam int unsigned CW = 2;
  localparam int unsigned MASK = (1 << W) - 1;

  logic          clk;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic          cmd_dir;
  logic [W-1:0]  cmd_data;
  logic [CW-1:0] cmd_amt;
  logic          cmd_fill;
  logic          sin_ext;
  logic          ser_bit;
  logic          ser_valid;
  logic [W-1:0]  result;
  logic          done;
  logic          err;
  logic          reg_enb;
  logic          reg_dir;
  logic          reg_sin;
  logic [1:0]    reg_modo;
  logic [W-1:0]  reg_d;
  logic [W-1:0]  q_m;
  logic          reg_sout;

  int n_checks = 0;
  int n_fail   = 0;

  control_registro_desplazable #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .RST_N(rst_n),
    .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready), .CMD_OP(cmd_op), .CMD_DIR(cmd_dir),
    .CMD_DATA(cmd_data), .CMD_AMT(cmd_amt), .CMD_FILL(cmd_fill), .SIN_EXT(sin_ext),
    .SER_BIT(ser_bit), .SER_VALID(ser_valid), .RESULT(result), .DONE(done), .ERR(err),
    .REG_ENB(reg_enb), .REG_DIR(reg_dir), .REG_SIN(reg_sin), .REG_MODO(reg_modo),
    .REG_D(reg_d), .REG_Q(q_m), .REG_SOUT(reg_sout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Attached shift register
  always_ff @(posedge clk) begin
    if (reg_enb) begin
      case (reg_modo)
        2'b00:   q_m <= reg_dir ? {reg_sin, q_m[W-1:1]} : {q_m[W-2:0], reg_sin};
        2'b01:   q_m <= reg_dir ? {q_m[0], q_m[W-1:1]} : {q_m[W-2:0], q_m[W-1]};
        2'b10:   q_m <= reg_d;
        default: q_m <= q_m;
      endcase
    end
  end
  assign reg_sout = reg_dir ? q_m[0] : q_m[W-1];

  // Reference results
  function automatic int exp_rot(input int data, input bit dir, input int amt);
    if (!dir) return ((data << amt) | (data >> (W - amt))) & MASK;
    return ((data >> amt) | (data << (W - amt))) & MASK;
  endfunction

  function automatic int exp_deser(input logic [7:0] s, input bit dir);
    int r = 0;
    for (int i = 0; i < W; i++) begin
      if (!dir) r = r * 2 + int'(s[i]);
      else      r = r / 2 + int'(s[i]) * (1 << (W - 1));
    end
    return r;
  endfunction

  function automatic int exp_ser_bits(input int data, input bit dir);
    int r = 0;
    for (int k = 0; k < W; k++) begin
      if (!dir) r = r | (((data >> (W - 1 - k)) & 1) << k);
      else      r = r | (((data >> k) & 1) << k);
    end
    return r;
  endfunction

  function automatic int exp_lat(input int op, input int amt);
    if (op == 0) return W + 1;
    if (op == 1) return amt + 1;
    return W;
  endfunction

  // Issues one command and records what the DUT did until DONE (or budget expiry: lat=-1)
  task automatic do_cmd(input logic [1:0] op, input logic dir, input logic [W-1:0] data,
                        input logic [CW-1:0] amt, input logic fill, input logic [7:0] sin,
                        output int lat, output int nload, output int nrot, output int nshift,
                        output int nser, output logic [15:0] ser, output logic [W-1:0] res,
                        output logic rdy_req, output logic rdy_busy);
    lat = -1; nload = 0; nrot = 0; nshift = 0; nser = 0; ser = '0; res = '0; rdy_busy = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_dir = dir; cmd_data = data; cmd_amt = amt;
    cmd_fill = fill; sin_ext = sin[0];
    rdy_req = cmd_ready;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      sin_ext = (k < 8) ? sin[k] : 1'b0;
      if (done) begin
        lat = k - 1;
        res = result;
        break;
      end
      if (cmd_ready) rdy_busy = 1'b1;
      if (reg_enb && reg_modo == 2'b10) nload++;
      if (reg_enb && reg_modo == 2'b01) nrot++;
      if (reg_enb && reg_modo == 2'b00) nshift++;
      if (ser_valid && nser < 16) begin
        ser[nser] = ser_bit;
        nser++;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_dir = 1'b0; cmd_data = '0;
    cmd_amt = '0; cmd_fill = 1'b0; sin_ext = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (reg_enb !== 1'b0) begin n_fail++; $display("FAIL reset_enb got=%b exp=0", reg_enb); end
    n_checks++; if (reg_modo !== 2'b00) begin n_fail++; $display("FAIL reset_modo got=%b exp=00", reg_modo); end
    n_checks++; if ({done, err, ser_valid} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got=%b exp=000", {done, err, ser_valid}); end
    n_checks++; if ({result, reg_d} !== '0) begin n_fail++; $display("FAIL reset_data got=%h/%h exp=0/0", result, reg_d); end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", cmd_ready); end
  endtask

  task automatic test_rotate;
    int lat, nl, nr, ns, nser; logic [15:0] ser; logic [W-1:0] res; logic rr, rb;
    do_cmd(2'b01, 1'b0, 4'b1010, 2'd1, 1'b0, 8'h00, lat, nl, nr, ns, nser, ser, res, rr, rb);
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL rot1_latency got=%0d exp=2", lat); end
    n_checks++; if (nl !== 1 || nr !== 1 || ns !== 0) begin n_fail++; $display("FAIL rot1_cycles got=load%0d rot%0d shift%0d exp=1/1/0", nl, nr, ns); end
    n_checks++; if (res !== 4'b0101) begin n_fail++; $display("FAIL rot1_result got=%b exp=0101", res); end
    @(negedge clk);
    n_checks++; if (done !== 1'b0 || result !== 4'b0101) begin n_fail++; $display("FAIL rot1_hold got=done%b res%b exp=0/0101", done, result); end
    do_cmd(2'b01, 1'b0, 4'b1010, 2'd0, 1'b0, 8'h00, lat, nl, nr, ns, nser, ser, res, rr, rb);
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL rot0_latency got=%0d exp=1", lat); end
    n_checks++; if (nl !== 1 || nr !== 0) begin n_fail++; $display("FAIL rot0_cycles got=load%0d rot%0d exp=1/0", nl, nr); end
    n_checks++; if (res !== 4'b1010) begin n_fail++; $display("FAIL rot0_result got=%b exp=1010", res); end
  endtask

  task automatic test_serialize;
    int lat, nl, nr, ns, nser; logic [15:0] ser; logic [W-1:0] res; logic rr, rb;
    do_cmd(2'b00, 1'b0, 4'b1101, 2'd0, 1'b0, 8'h00, lat, nl, nr, ns, nser, ser, res, rr, rb);
    n_checks++; if (nser !== 4) begin n_fail++; $display("FAIL ser_count got=%0d exp=4", nser); end
    n_checks++; if (ser[3:0] !== 4'b1011) begin n_fail++; $display("FAIL ser_bits got=%b exp=1011 (first bit in lsb)", ser[3:0]); end
    n_checks++; if (res !== 4'b0000) begin n_fail++; $display("FAIL ser_result got=%b exp=0000", res); end
    n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL ser_latency got=%0d exp=5", lat); end
  endtask

  task automatic test_deserialize;
    int lat, nl, nr, ns, nser; logic [15:0] ser; logic [W-1:0] res; logic rr, rb;
    do_cmd(2'b10, 1'b0, 4'b0000, 2'd0, 1'b0, 8'b0000_1001, lat, nl, nr, ns, nser, ser, res, rr, rb);
    n_checks++; if (res !== 4'b1001) begin n_fail++; $display("FAIL des_left_result got=%b exp=1001", res); end
    n_checks++; if (lat !== 4 || ns !== 4 || nser !== 0) begin n_fail++; $display("FAIL des_left_timing got=lat%0d shifts%0d ser%0d exp=4/4/0", lat, ns, nser); end
    do_cmd(2'b10, 1'b1, 4'b0000, 2'd0, 1'b0, 8'b0000_1001, lat, nl, nr, ns, nser, ser, res, rr, rb);
    n_checks++; if (res !== 4'b1001) begin n_fail++; $display("FAIL des_right_result got=%b exp=1001", res); end
  endtask

  task automatic test_illegal;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b11;
    @(negedge clk);
    cmd_valid = 1'b0;
    n_checks++; if (err !== 1'b1 || reg_enb !== 1'b0) begin n_fail++; $display("FAIL ill_err got=err%b enb%b exp=1/0", err, reg_enb); end
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL ill_ready got=%b exp=1", cmd_ready); end
    @(negedge clk);
    n_checks++; if (err !== 1'b0 || reg_enb !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL ill_pulse got=err%b enb%b done%b exp=0/0/0", err, reg_enb, done); end
  endtask

  task automatic test_back_to_back;
    int lat;
    bit bad_rdy;
    lat = -1; bad_rdy = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_dir = 1'b0; sin_ext = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      cmd_op = 2'b01; cmd_data = 4'b1010; cmd_amt = 2'd1;
      if (cmd_ready || reg_modo == 2'b10) bad_rdy = 1;
      if (done) begin lat = k - 1; break; end
    end
    n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL b2b_des_latency got=%0d exp=4", lat); end
    n_checks++; if (bad_rdy !== 0) begin n_fail++; $display("FAIL b2b_busy_accept got=%0d exp=0", bad_rdy); end
    @(negedge clk);
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_after_done got=%b exp=1", cmd_ready); end
    @(negedge clk);
    cmd_valid = 1'b0;
    n_checks++; if (reg_enb !== 1'b1 || reg_modo !== 2'b10) begin n_fail++; $display("FAIL b2b_second_load got=enb%b modo%b exp=1/10", reg_enb, reg_modo); end
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (done) begin lat = k; break; end
    end
    n_checks++; if (lat !== 2 || result !== 4'b0101) begin n_fail++; $display("FAIL b2b_second_done got=wait%0d res%b exp=2/0101", lat, result); end
  endtask

  task automatic test_random;
    int lat, nl, nr, ns, nser; logic [15:0] ser; logic [W-1:0] res; logic rr, rb;
    logic [1:0] op; logic dir, fill; logic [W-1:0] data; logic [CW-1:0] amt; logic [7:0] sin;
    int e_res, e_lat;
    for (int it = 0; it < 40; it++) begin
      op = 2'($urandom_range(0, 2)); dir = 1'($urandom); fill = 1'($urandom);
      data = W'($urandom); amt = CW'($urandom); sin = 8'($urandom);
      do_cmd(op, dir, data, amt, fill, sin, lat, nl, nr, ns, nser, ser, res, rr, rb);
      e_lat = exp_lat(int'(op), int'(amt));
      if (op == 2'b00)      e_res = fill ? int'(MASK) : 0;
      else if (op == 2'b01) e_res = exp_rot(int'(data), dir, int'(amt));
      else                  e_res = exp_deser(sin, dir);
      n_checks++; if (int'(res) !== e_res) begin n_fail++; $display("FAIL rnd_result it=%0d op=%0d got=%0h exp=%0h", it, op, res, e_res); end
      n_checks++; if (lat !== e_lat) begin n_fail++; $display("FAIL rnd_latency it=%0d op=%0d got=%0d exp=%0d", it, op, lat, e_lat); end
      n_checks++; if (rr !== 1'b1 || rb !== 1'b0) begin n_fail++; $display("FAIL rnd_ready it=%0d got=req%b busy%b exp=1/0", it, rr, rb); end
      if (op == 2'b00) begin
        n_checks++; if (nser !== 4 || int'(ser[3:0]) !== exp_ser_bits(int'(data), dir)) begin n_fail++; $display("FAIL rnd_ser it=%0d got=n%0d bits%b exp=4/%0h", it, nser, ser[3:0], exp_ser_bits(int'(data), dir)); end
      end else if (op == 2'b01) begin
        n_checks++; if (nr !== int'(amt) || nser !== 0) begin n_fail++; $display("FAIL rnd_rotcycles it=%0d got=%0d/%0d exp=%0d/0", it, nr, nser, amt); end
      end
      @(negedge clk);
      n_checks++; if (done !== 1'b0 || int'(result) !== e_res) begin n_fail++; $display("FAIL rnd_hold it=%0d got=done%b res%0h exp=0/%0h", it, done, result, e_res); end
    end
  endtask

  task automatic test_reset_mid_rot;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_dir = 1'b0; cmd_data = 4'b0110; cmd_amt = 2'd3;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (reg_enb !== 1'b1 || reg_modo !== 2'b01) begin n_fail++; $display("FAIL mid_rot_active got=enb%b modo%b exp=1/01", reg_enb, reg_modo); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (reg_enb !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL mid_rot_abort got=enb%b done%b exp=0/0", reg_enb, done); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (cmd_ready !== 1'b1 || done !== 1'b0 || reg_enb !== 1'b0) begin n_fail++; $display("FAIL mid_rot_recover got=rdy%b done%b enb%b exp=1/0/0", cmd_ready, done, reg_enb); end
  endtask

  initial begin
    test_reset();
    test_rotate();
    test_serialize();
    test_deserialize();
    test_illegal();
    test_back_to_back();
    test_random();
    test_reset_mid_rot();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
